// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and two's-complement helpers.
package muldiv_pkg;

  localparam int unsigned MAX_W = 128;
  typedef logic [MAX_W-1:0] wide_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  function automatic wide_t twos_neg(input wide_t x);
    return ~x + wide_t'(1);
  endfunction

  // Callers truncate the result to their own width; the low bits are exact.
  function automatic wide_t cond_neg(input wide_t x, input logic neg);
    return neg ? twos_neg(x) : x;
  endfunction

  function automatic logic a_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RISC-V M-extension unit: one shared 2W shift register and
// one W+1-bit adder/subtractor serve both multiply and divide.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  kill_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [W-1:0]    m_q, m_d;
  logic [2*W-1:0]  p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    res_q, res_d;

  logic [W:0]      add_a, add_b;
  logic            add_cin;
  logic [W+1:0]    add_sum;
  logic [2*W-1:0]  step;
  logic [W-1:0]    abs_a, abs_b;
  logic [2*W-1:0]  fix_w;
  op_e             op_in;

  assign op_in = op_e'(op_i);

  // Divide: trial-subtract divisor from {rem, next dividend bit}; carry-out
  // set means no borrow. Multiply: conditionally add multiplicand to high half.
  always_comb begin
    if (op_q[2]) begin
      add_a   = p_q[2*W-1:W-1];
      add_b   = ~{1'b0, m_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, p_q[2*W-1:W]};
      add_b   = p_q[0] ? {1'b0, m_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + (W+2)'(add_cin);
    if (op_q[2]) begin
      if (add_sum[W+1]) step = {add_sum[W-1:0], p_q[W-2:0], 1'b1};
      else              step = {p_q[2*W-2:W-1], p_q[W-2:0], 1'b0};
    end else begin
      step = {add_sum[W:0], p_q[W-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    fix_w   = '0;
    abs_a   = W'(cond_neg(wide_t'(a_i), a_signed(op_in) & a_i[W-1]));
    abs_b   = W'(cond_neg(wide_t'(b_i), b_signed(op_in) & b_i[W-1]));

    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d  = op_in;
          sa_d  = a_signed(op_in) & a_i[W-1];
          sb_d  = b_signed(op_in) & b_i[W-1];
          cnt_d = '0;
          if (op_i[2]) begin
            m_d = abs_b;
            p_d = {W'(0), abs_a};
          end else begin
            m_d = abs_a;
            p_d = {W'(0), abs_b};
          end
          if (op_i[2] && b_i == '0) begin
            res_d   = op_i[1] ? a_i : '1;
            state_d = DONE;
          end else if (op_i[2] && !op_i[0] && a_i == {1'b1, {(W-1){1'b0}}} && b_i == '1) begin
            res_d   = op_i[1] ? '0 : a_i;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d   = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) state_d = FIX;
      end
      FIX: begin
        if (!op_q[2])
          fix_w = (2*W)'(cond_neg(wide_t'(p_q), sa_q ^ sb_q));
        else if (!op_q[1])
          fix_w = (2*W)'(cond_neg(wide_t'(p_q[W-1:0]), sa_q ^ sb_q));
        else
          fix_w = (2*W)'(cond_neg(wide_t'(p_q[2*W-1:W]), sa_q));
        res_d   = (op_q == OP_MUL || op_q[2]) ? fix_w[W-1:0] : fix_w[2*W-1:W];
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (kill_i) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign res_o   = res_q;

endmodule
